// File: rtl/junction_controller.sv
// Junction controller: sequences main road A, side road B and a pedestrian
// walk phase. Owns the phase down-counter and the B / pedestrian request
// latches. Lamps are decoded from the state register alone.
module junction_controller #(
  parameter int CNT_W       = 4,
  parameter int T_GREEN_MIN = 8,
  parameter int T_GREEN_B   = 6,
  parameter int T_AMBER     = 3,
  parameter int T_RED_AMBER = 2,
  parameter int T_ALL_RED   = 1,
  parameter int T_WALK      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       b_sensor,
  input  logic       ped_req,
  output logic       a_red,
  output logic       a_amber,
  output logic       a_green,
  output logic       b_red,
  output logic       b_amber,
  output logic       b_green,
  output logic       walk,
  output logic       ped_wait,
  output logic [3:0] state
);

  localparam logic [3:0] S_ALL_RED     = 4'd0;
  localparam logic [3:0] S_A_RED_AMBER = 4'd1;
  localparam logic [3:0] S_A_GREEN     = 4'd2;
  localparam logic [3:0] S_A_AMBER     = 4'd3;
  localparam logic [3:0] S_PED_WALK    = 4'd4;
  localparam logic [3:0] S_B_RED_AMBER = 4'd5;
  localparam logic [3:0] S_B_GREEN     = 4'd6;
  localparam logic [3:0] S_B_AMBER     = 4'd7;

  localparam logic DIR_A = 1'b0;
  localparam logic DIR_B = 1'b1;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             dir_q, dir_d;
  // Set once the walk has been served in the current all-red pair, so a
  // request raised during the following ALL_RED waits for the next pair.
  logic             ped_done_q, ped_done_d;
  logic             b_pend_q, b_pend_d;
  logic             ped_pend_q, ped_pend_d;
  logic             expired;

  assign expired = (timer_q == '0);

  // Timer value loaded on entry: dwell minus one, so the state lasts N cycles.
  function automatic logic [CNT_W-1:0] dwell_load(input logic [3:0] s);
    case (s)
      S_A_RED_AMBER, S_B_RED_AMBER: dwell_load = CNT_W'(T_RED_AMBER - 1);
      S_A_GREEN:                    dwell_load = CNT_W'(T_GREEN_MIN - 1);
      S_A_AMBER, S_B_AMBER:         dwell_load = CNT_W'(T_AMBER - 1);
      S_PED_WALK:                   dwell_load = CNT_W'(T_WALK - 1);
      S_B_GREEN:                    dwell_load = CNT_W'(T_GREEN_B - 1);
      default:                      dwell_load = CNT_W'(T_ALL_RED - 1);
    endcase
  endfunction

  // Phase sequencing and direction bookkeeping.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    ped_done_d = ped_done_q;
    case (state_q)
      S_ALL_RED: begin
        if (expired) begin
          if (ped_pend_q && !ped_done_q) begin
            state_d = S_PED_WALK;
          end else begin
            state_d    = (dir_q == DIR_B) ? S_B_RED_AMBER : S_A_RED_AMBER;
            ped_done_d = 1'b0;
          end
        end
      end
      S_A_RED_AMBER: if (expired) state_d = S_A_GREEN;
      S_A_GREEN:     if (expired && (b_pend_q || ped_pend_q)) state_d = S_A_AMBER;
      S_A_AMBER: begin
        if (expired) begin
          state_d = S_ALL_RED;
          dir_d   = DIR_B;
        end
      end
      S_PED_WALK: begin
        if (expired) begin
          state_d    = S_ALL_RED;
          dir_d      = b_pend_q ? DIR_B : DIR_A;
          ped_done_d = 1'b1;
        end
      end
      S_B_RED_AMBER: if (expired) state_d = S_B_GREEN;
      S_B_GREEN:     if (expired) state_d = S_B_AMBER;
      S_B_AMBER: begin
        if (expired) begin
          state_d = S_ALL_RED;
          dir_d   = DIR_A;
        end
      end
      default: begin
        state_d    = S_ALL_RED;
        dir_d      = DIR_A;
        ped_done_d = 1'b0;
      end
    endcase
  end

  // Phase timer: reload on any state change, otherwise count down and hold at 0.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = dwell_load(state_d);
    end else if (!expired) begin
      timer_d = timer_q - 1'b1;
    end
  end

  // Request latches: set wins over hold; the entry edge of the serving phase clears.
  always_comb begin
    ped_pend_d = ped_pend_q | (ped_req && (state_q != S_PED_WALK));
    if ((state_d == S_PED_WALK) && (state_q != S_PED_WALK)) ped_pend_d = 1'b0;
    b_pend_d = b_pend_q |
               (b_sensor && (state_q != S_B_RED_AMBER) && (state_q != S_B_GREEN));
    if ((state_d == S_B_GREEN) && (state_q != S_B_GREEN)) b_pend_d = 1'b0;
  end

  // State, timer and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_ALL_RED;
      timer_q    <= CNT_W'(T_ALL_RED);
      dir_q      <= DIR_A;
      ped_done_q <= 1'b0;
      b_pend_q   <= 1'b0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      dir_q      <= dir_d;
      ped_done_q <= ped_done_d;
      b_pend_q   <= b_pend_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  // Lamp decode from the state register; unknown encodings show all red.
  always_comb begin
    a_red   = 1'b0;
    a_amber = 1'b0;
    a_green = 1'b0;
    b_red   = 1'b0;
    b_amber = 1'b0;
    b_green = 1'b0;
    walk    = 1'b0;
    case (state_q)
      S_A_RED_AMBER: begin a_red = 1'b1; a_amber = 1'b1; b_red = 1'b1; end
      S_A_GREEN:     begin a_green = 1'b1; b_red = 1'b1; end
      S_A_AMBER:     begin a_amber = 1'b1; b_red = 1'b1; end
      S_PED_WALK:    begin a_red = 1'b1; b_red = 1'b1; walk = 1'b1; end
      S_B_RED_AMBER: begin a_red = 1'b1; b_red = 1'b1; b_amber = 1'b1; end
      S_B_GREEN:     begin a_red = 1'b1; b_green = 1'b1; end
      S_B_AMBER:     begin a_red = 1'b1; b_amber = 1'b1; end
      default:       begin a_red = 1'b1; b_red = 1'b1; end
    endcase
  end

  assign ped_wait = ped_pend_q;
  assign state    = state_q;

endmodule

// File: tb/tb_junction_controller.sv
// Self-checking bench for junction_controller: directed scenarios followed by
// randomized requests, compared cycle by cycle against a phase-level model.
module tb_junction_controller;

  localparam int T_AR  = 1;
  localparam int T_ARA = 2;
  localparam int T_AG  = 8;
  localparam int T_AA  = 3;
  localparam int T_WK  = 5;
  localparam int T_BRA = 2;
  localparam int T_BG  = 6;
  localparam int T_BA  = 3;

  // Lamp words: {a_red,a_amber,a_green,b_red,b_amber,b_green,walk,ped_wait}
  localparam logic [7:0] L_AR   = 8'b1001_0000;
  localparam logic [7:0] L_ARA  = 8'b1101_0000;
  localparam logic [7:0] L_AG   = 8'b0011_0000;
  localparam logic [7:0] L_AA   = 8'b0101_0000;
  localparam logic [7:0] L_WALK = 8'b1001_0010;
  localparam logic [7:0] L_BRA  = 8'b1001_1000;
  localparam logic [7:0] L_BG   = 8'b1000_0100;
  localparam logic [7:0] L_BA   = 8'b1000_1000;

  logic       clk = 1'b0;
  logic       rst_n, b_sensor, ped_req;
  logic       a_red, a_amber, a_green, b_red, b_amber, b_green, walk, ped_wait;
  logic [3:0] state;
  logic [7:0] obs;
  logic [7:0] hist [256];

  int checks = 0;
  int fails  = 0;
  int cyc    = -1;

  // Model: phase name, cycles spent in it, latched requests, direction memory.
  string ph;
  int    spent;
  bit    pw, bw, dirb, walked;

  junction_controller #(
    .CNT_W(4), .T_GREEN_MIN(T_AG), .T_GREEN_B(T_BG), .T_AMBER(T_AA),
    .T_RED_AMBER(T_ARA), .T_ALL_RED(T_AR), .T_WALK(T_WK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .b_sensor(b_sensor), .ped_req(ped_req),
    .a_red(a_red), .a_amber(a_amber), .a_green(a_green),
    .b_red(b_red), .b_amber(b_amber), .b_green(b_green),
    .walk(walk), .ped_wait(ped_wait), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {a_red, a_amber, a_green, b_red, b_amber, b_green, walk, ped_wait};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, o, e);
    end
  endtask

  function automatic logic [7:0] exp_lamps(input string p, input bit pwv);
    logic [7:0] l;
    case (p)
      "AR":    l = L_AR;
      "ARA":   l = L_ARA;
      "AG":    l = L_AG;
      "AA":    l = L_AA;
      "WALK":  l = L_WALK;
      "BRA":   l = L_BRA;
      "BG":    l = L_BG;
      "BA":    l = L_BA;
      default: l = 8'hFF;
    endcase
    l[0] = pwv;
    return l;
  endfunction

  function automatic bit legal(input logic r, input logic a, input logic g);
    return ({r, a, g} == 3'b100) || ({r, a, g} == 3'b010) ||
           ({r, a, g} == 3'b001) || ({r, a, g} == 3'b110);
  endfunction

  task automatic model_reset();
    ph = "AR"; spent = -1; pw = 0; bw = 0; dirb = 0; walked = 0;
  endtask

  task automatic model_step(input bit b, input bit p);
    string nx;
    bit    np, nb;
    nx = ph;
    spent++;
    case (ph)
      "AR": if (spent >= T_AR) begin
        if (pw && !walked) nx = "WALK";
        else begin
          if (dirb) nx = "BRA"; else nx = "ARA";
          walked = 0;
        end
      end
      "ARA":  if (spent >= T_ARA) nx = "AG";
      "AG":   if (spent >= T_AG && (bw || pw)) nx = "AA";
      "AA":   if (spent >= T_AA) begin nx = "AR"; dirb = 1; end
      "WALK": if (spent >= T_WK) begin nx = "AR"; dirb = bw; walked = 1; end
      "BRA":  if (spent >= T_BRA) nx = "BG";
      "BG":   if (spent >= T_BG) nx = "BA";
      "BA":   if (spent >= T_BA) begin nx = "AR"; dirb = 0; end
      default: ;
    endcase
    np = pw | (p && ph != "WALK");
    if (nx == "WALK" && ph != "WALK") np = 0;
    nb = bw | (b && ph != "BRA" && ph != "BG");
    if (nx == "BG" && ph != "BG") nb = 0;
    pw = np;
    bw = nb;
    if (nx != ph) spent = 0;
    ph = nx;
  endtask

  task automatic tick(input bit b, input bit p);
    b_sensor = b;
    ped_req  = p;
    @(posedge clk);
    cyc++;
    model_step(b, p);
    #1;
    if (cyc >= 0 && cyc < 256) hist[cyc] = obs;
    chk("lamps", 32'(obs), 32'(exp_lamps(ph, pw)));
  endtask

  task automatic chkh(input string tag, input int idx, input logic [7:0] e);
    chk(tag, 32'(hist[idx]), 32'(e));
  endtask

  // Mid-cycle asynchronous reset, held for two edges, released before edge 0.
  task automatic do_reset();
    #2;
    b_sensor = 0;
    ped_req  = 0;
    rst_n    = 0;
    #1;
    chk("async_reset", 32'(obs), 32'(L_AR));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1;
    cyc   = -1;
  endtask

  // Safety invariants sampled on the falling edge, every cycle.
  always @(negedge clk) begin
    chk("inv_conflict", 32'(a_red | b_red), 32'd1);
    chk("inv_walk", 32'(!walk || (a_red && b_red)), 32'd1);
    chk("inv_road_a", 32'(legal(a_red, a_amber, a_green)), 32'd1);
    chk("inv_road_b", 32'(legal(b_red, b_amber, b_green)), 32'd1);
    chk("state_known", 32'(^state !== 1'bx), 32'd1);
  end

  initial begin
    bit bl;
    rst_n = 1; b_sensor = 0; ped_req = 0;
    model_reset();
    #1 rst_n = 0;
    #1 chk("reset_state", 32'(obs), 32'(L_AR));
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1;

    // No requests: A rests on green.
    while (cyc < 62) tick(0, 0);
    chkh("s1_c1_red_amber", 1, L_ARA);
    chkh("s1_c2_red_amber", 2, L_ARA);
    chkh("s1_c3_green", 3, L_AG);
    chkh("s1_c62_green", 62, L_AG);

    // B request from cycle 5 (dropped once B is green).
    do_reset();
    while (cyc < 30) tick(cyc >= 5 && cyc < 17, 0);
    chkh("s2_min_dwell", 10, L_AG);
    chkh("s2_a_amber", 11, L_AA);
    chkh("s2_a_amber_end", 13, L_AA);
    chkh("s2_all_red", 14, L_AR);
    chkh("s2_b_red_amber", 15, L_BRA);
    chkh("s2_b_green", 17, L_BG);
    chkh("s2_b_green_end", 22, L_BG);
    chkh("s2_b_amber", 23, L_BA);
    chkh("s2_all_red2", 26, L_AR);
    chkh("s2_a_red_amber", 27, L_ARA);
    chkh("s2_a_green", 29, L_AG);

    // Single-cycle pedestrian pulse at cycle 30.
    while (cyc < 60) tick(0, cyc == 30);
    chkh("s3_wait_lit", 31, L_AG | 8'h01);
    chkh("s3_a_amber", 37, L_AA | 8'h01);
    chkh("s3_all_red", 40, L_AR | 8'h01);
    chkh("s3_walk_first", 41, L_WALK);
    chkh("s3_walk_last", 45, L_WALK);
    chkh("s3_all_red2", 46, L_AR);
    chkh("s3_a_green_no_b", 49, L_AG);
    chkh("s3_still_green", 59, L_AG);

    // Pedestrian and B requests in the same cycle.
    while (cyc < 100) tick(cyc == 60, cyc == 60);
    chkh("s4_a_amber", 62, L_AA | 8'h01);
    chkh("s4_walk_first", 66, L_WALK);
    chkh("s4_walk_last", 70, L_WALK);
    chkh("s4_all_red", 71, L_AR);
    chkh("s4_b_red_amber", 72, L_BRA);
    chkh("s4_b_green", 74, L_BG);
    chkh("s4_b_green_end", 79, L_BG);
    chkh("s4_b_amber", 80, L_BA);

    // Pedestrian pulse during the walk is ignored.
    while (cyc < 130) tick(0, cyc == 100 || cyc == 107);
    chkh("s5_walk", 106, L_WALK);
    chkh("s5_walk_ignored", 108, L_WALK);
    chkh("s5_all_red", 111, L_AR);
    chkh("s5_a_green", 114, L_AG);
    chkh("s5_no_second_walk", 129, L_AG);

    // Reset asserted while B is green, then restart from scratch.
    while (cyc < 139) tick(cyc == 130, 0);
    chkh("s6_in_b_green", 139, L_BG);
    do_reset();
    while (cyc < 5) tick(0, 0);
    chkh("s6_restart_red_amber", 1, L_ARA);
    chkh("s6_restart_green", 3, L_AG);

    // Randomized traffic with occasional resets.
    bl = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) bl = ~bl;
      tick(bl, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/junction_controller.md
Name: junction_controller

Overview:
- Sequences two trafficlights-style light sets: main road A and side road B. Also runs a pedestrian crossing phase.
- Sits above the per-road light outputs and owns the phase timer and request latching.
- Guarantees that conflicting greens and walk are never shown together.
- Road A rests on green. Road B and the pedestrian phase are served on request.

Parameters:
- CNT_W, 4, width of the phase down-counter.
- T_GREEN_MIN, 8, minimum A_GREEN dwell in cycles.
- T_GREEN_B, 6, fixed B_GREEN dwell in cycles.
- T_AMBER, 3, dwell of A_AMBER and B_AMBER.
- T_RED_AMBER, 2, dwell of A_RED_AMBER and B_RED_AMBER.
- T_ALL_RED, 1, dwell of ALL_RED.
- T_WALK, 5, dwell of PED_WALK.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- b_sensor  in  1  level: vehicle waiting on road B.
- ped_req  in  1  pedestrian button, any pulse width of 1 or more cycles.
- a_red, a_amber, a_green  out  1 each  road A lamps.
- b_red, b_amber, b_green  out  1 each  road B lamps.
- walk  out  1  pedestrian walk lamp.
- ped_wait  out  1  request-acknowledged lamp; equals ped_pend.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset (async, rst_n=0):
  - state=ALL_RED, next_dir=A, timer=T_ALL_RED.
  - b_pend=0, ped_pend=0.
  - Outputs: a_red=b_red=1, all other lamps 0.
- Dwell rule: a state entered at edge k is left at edge k+N, where N is its dwell parameter.
  - The timer loads N-1 on entry and decrements each cycle.
  - "expired" means timer==0.
- States, their lamps and transitions:
  - ALL_RED (a_red, b_red). On expiry:
    - ped_pend=1 and next_dir!=PED_DONE -> PED_WALK;
    - else if next_dir=B -> B_RED_AMBER;
    - else -> A_RED_AMBER.
  - A_RED_AMBER (a_red, a_amber, b_red) -> A_GREEN on expiry.
  - A_GREEN (a_green, b_red):
    - Leaves only when expired and (b_pend|ped_pend), going to A_AMBER.
    - Otherwise holds indefinitely; the timer saturates at 0.
  - A_AMBER (a_amber, b_red) -> ALL_RED with next_dir=B.
  - PED_WALK (a_red, b_red, walk) -> ALL_RED on expiry.
    - On exit sets next_dir=B if b_pend, else A.
    - ped_pend is cleared on entry.
  - B_RED_AMBER (a_red, b_red, b_amber) -> B_GREEN.
  - B_GREEN (a_red, b_green): fixed T_GREEN_B dwell, then -> B_AMBER. b_pend is cleared on entry.
  - B_AMBER (a_red, b_amber) -> ALL_RED with next_dir=A.
- Request latching:
  - ped_pend is set on any sampled ped_req=1, except while in PED_WALK, where requests are ignored.
  - b_pend is set on b_sensor=1 in any state other than B_RED_AMBER and B_GREEN.
  - Set has priority over clear when they occur on the same edge, except the entry-clear edge.
- Pedestrian phase timing: PED_WALK may occur after A_AMBER or after B_AMBER, whichever ALL_RED comes first with ped_pend=1. It is taken at most once per ALL_RED pair.
- Simultaneous requests: b_sensor and ped_req arriving in the same cycle give the sequence PED_WALK, then ALL_RED, then B phase.
- Invariants, required every cycle:
  - Never both roads non-red.
  - walk=1 only if a_red=b_red=1.
  - Exactly one of {red, amber, green, red+amber} per road.
- Outputs are registered, decoded from the state register only.
- Unused state encodings force ALL_RED with next_dir=A.
- Reset asserted mid-phase: immediately all-red, pending requests lost.

Test Plan:
- No requests: release rst_n at edge 0.
  - a_red & a_amber at cycles 1-2.
  - a_green from cycle 3, held for 60 cycles.
  - b_red=1 throughout, walk=0.
- b_sensor=1 from cycle 5: A_GREEN still lasts to cycle 11 (min dwell).
  - a_amber 11-13, all red 14, b red+amber 15-16, b_green 17-22, b_amber 23-25.
  - all red 26, then A red+amber 27-28, a_green from 29.
- ped_req single-cycle pulse at cycle 30 after the A rest:
  - ped_wait=1 from 31.
  - A_AMBER for 3 cycles, ALL_RED 1 cycle, then walk=1 for 5 cycles with ped_wait=0.
  - ALL_RED, then A red+amber, then a_green. No B phase.
- ped_req and b_sensor in the same cycle: order A_AMBER, ALL_RED, PED_WALK(5), ALL_RED, B_RED_AMBER, B_GREEN(6).
  - b_pend stays set through the walk.
- ped_req pulsed during PED_WALK: ignored, ped_wait stays 0, no second walk.
- rst_n low during B_GREEN: all outputs go to all-red asynchronously (same cycle).
  - After release, the sequence restarts as in scenario 1.
  - A bench monitor checks every invariant on every cycle across all scenarios.
